// File: rtl/neuron_tile_sequencer.sv
// Sequences one dot product: clear, issue Num_Tiles tiles, drain the neuron pipeline, hand off the sum.
// Optional NEURON_SEQ_RELU_EN clamps negative sums to zero at the capture edge.
module neuron_tile_sequencer #(
  parameter int TILE_CNT_W = 8,
  parameter int PIPE_DEPTH = 6,
  parameter int DATA_W     = 26
) (
  input  logic                  Clk,
  input  logic                  GlobalReset_n,
  input  logic                  Start_Valid,
  output logic                  Start_Ready,
  input  logic [TILE_CNT_W-1:0] Num_Tiles,
  output logic                  Busy,
  output logic [TILE_CNT_W-1:0] Tile_Idx,
  output logic                  Tile_Gate,
  output logic                  Neuron_Reset,
  input  logic [DATA_W-1:0]     Neuron_Out,
  output logic [DATA_W-1:0]     Res_Data,
  output logic                  Res_Valid,
  input  logic                  Res_Ready
);

  localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                  start_ready_d, busy_d, tile_gate_d, neuron_reset_d, res_valid_d;
  logic [TILE_CNT_W-1:0] tile_idx_d;
  logic [DATA_W-1:0]     res_data_d;
  logic                  accept;
  logic [TILE_CNT_W-1:0] last_idx;

  function automatic logic [DATA_W-1:0] capture_result(input logic signed [DATA_W-1:0] sum);
`ifdef NEURON_SEQ_RELU_EN
    capture_result = (sum < 0) ? '0 : sum;
`else
    capture_result = sum;
`endif
  endfunction

  assign accept   = Start_Valid & Start_Ready;
  assign last_idx = tile_cnt_q - TILE_CNT_W'(1);

  // State and registered outputs
  always_ff @(posedge Clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_q      <= S_IDLE;
      tile_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      Start_Ready  <= 1'b0;
      Busy         <= 1'b0;
      Tile_Idx     <= '0;
      Tile_Gate    <= 1'b0;
      Neuron_Reset <= 1'b1;
      Res_Data     <= '0;
      Res_Valid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_cnt_q   <= tile_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      Start_Ready  <= start_ready_d;
      Busy         <= busy_d;
      Tile_Idx     <= tile_idx_d;
      Tile_Gate    <= tile_gate_d;
      Neuron_Reset <= neuron_reset_d;
      Res_Data     <= res_data_d;
      Res_Valid    <= res_valid_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (Num_Tiles == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: if (Tile_Idx == last_idx) state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (Res_Ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it after the edge
  always_comb begin
    start_ready_d  = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
    tile_gate_d    = (state_d == S_ISSUE);
    neuron_reset_d = (state_d == S_CLEAR);
    res_valid_d    = (state_d == S_DONE);
    tile_idx_d     = '0;
    tile_cnt_d     = tile_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    res_data_d     = Res_Data;

    if (state_q == S_ISSUE && state_d == S_ISSUE)
      tile_idx_d = Tile_Idx + TILE_CNT_W'(1);

    if (state_q == S_IDLE && accept) begin
      tile_cnt_d = Num_Tiles;
      if (Num_Tiles == '0)
        res_data_d = '0;
    end

    if (state_q == S_ISSUE && state_d == S_DRAIN)
      drain_cnt_d = DRAIN_LOAD;
    else if (state_q == S_DRAIN && drain_cnt_q != '0)
      drain_cnt_d = drain_cnt_q - DRAIN_W'(1);

    if (state_q == S_DRAIN && drain_cnt_q == '0)
      res_data_d = capture_result(Neuron_Out);
  end

endmodule

// File: tb/tb_neuron_tile_sequencer.sv
// Bench for neuron_tile_sequencer: behavioural neuron pipeline plus a scoreboard of golden dot products.
module tb_neuron_tile_sequencer;
  localparam int TILE_CNT_W = 8;
  localparam int PIPE_DEPTH = 6;
  localparam int DATA_W     = 26;

  logic                  Clk;
  logic                  GlobalReset_n;
  logic                  Start_Valid;
  logic                  Start_Ready;
  logic [TILE_CNT_W-1:0] Num_Tiles;
  logic                  Busy;
  logic [TILE_CNT_W-1:0] Tile_Idx;
  logic                  Tile_Gate;
  logic                  Neuron_Reset;
  logic [DATA_W-1:0]     Neuron_Out;
  logic [DATA_W-1:0]     Res_Data;
  logic                  Res_Valid;
  logic                  Res_Ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = 0;
  logic [DATA_W-1:0] exp_q[$];

  neuron_tile_sequencer #(
    .TILE_CNT_W(TILE_CNT_W),
    .PIPE_DEPTH(PIPE_DEPTH),
    .DATA_W    (DATA_W)
  ) dut (
    .Clk          (Clk),
    .GlobalReset_n(GlobalReset_n),
    .Start_Valid  (Start_Valid),
    .Start_Ready  (Start_Ready),
    .Num_Tiles    (Num_Tiles),
    .Busy         (Busy),
    .Tile_Idx     (Tile_Idx),
    .Tile_Gate    (Tile_Gate),
    .Neuron_Reset (Neuron_Reset),
    .Neuron_Out   (Neuron_Out),
    .Res_Data     (Res_Data),
    .Res_Valid    (Res_Valid),
    .Res_Ready    (Res_Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Tile contents; weights are Q8 fixed point (256 = 1.0)
  function automatic int pix(input int k, input int l, input int m);
    case (m)
      0:       return 1;
      1:       return (k + l) % 7 + 1;
      default: return (l == 0) ? 1 : 0;
    endcase
  endfunction

  function automatic int wgt(input int k, input int l, input int m);
    case (m)
      0:       return 256;
      1:       return ((k * 3 + l) % 9 - 4) * 32;
      default: return (k == 0) ? -512 : -256;
    endcase
  endfunction

  function automatic int tile_dot(input int k, input int m);
    int s = 0;
    for (int l = 0; l < 16; l++) s += pix(k, l, m) * wgt(k, l, m);
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] golden(input int n, input int m);
    int s = 0;
    for (int k = 0; k < n; k++) s += tile_dot(k, m);
`ifdef NEURON_SEQ_RELU_EN
    if (s < 0) s = 0;
`endif
    return DATA_W'(s);
  endfunction

  // Behavioural neuron: mult 1 + tree 4 stages, then accumulator
  logic signed [DATA_W-1:0] dl [PIPE_DEPTH-1];
  logic signed [DATA_W-1:0] acc;
  always @(posedge Clk) begin
    if (Neuron_Reset) begin
      for (int i = 0; i < PIPE_DEPTH - 1; i++) dl[i] <= '0;
      acc <= '0;
    end else begin
      dl[0] <= Tile_Gate ? DATA_W'(tile_dot(int'(Tile_Idx), mode)) : '0;
      for (int i = 1; i < PIPE_DEPTH - 1; i++) dl[i] <= dl[i-1];
      acc <= acc + dl[PIPE_DEPTH-2];
    end
  end
  assign Neuron_Out = acc;

  task automatic do_job(input int n, input int m, input int hold, input bit keep_valid,
                        input string tag);
    int s, t, k, lat, v;
    bit seq_bad, hold_bad, seen;
    logic [DATA_W-1:0] exp_v, got;
    lat = (n == 0) ? 1 : n + PIPE_DEPTH + 2;
    t = 0;
    while (Start_Ready !== 1'b1 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    checks++;
    if (Start_Ready !== 1'b1) begin
      errors++;
      $display("FAIL %s start_ready: got %b want 1", tag, Start_Ready);
      Start_Valid = 1'b0;
      return;
    end
    mode        = m;
    Num_Tiles   = TILE_CNT_W'(n);
    Start_Valid = 1'b1;
    Res_Ready   = (hold == 0);
    s           = cyc;
    exp_q.push_back(golden(n, m));
    seq_bad = 1'b0;
    seen    = 1'b0;
    v       = -1;
    while (!seen && (cyc - s) < lat + 20) begin
      @(negedge Clk);
      if (!keep_valid) Start_Valid = 1'b0;
      k = cyc - s;
      if (Busy !== 1'b1 || Start_Ready !== 1'b0) seq_bad = 1'b1;
      if (Neuron_Reset !== ((n != 0 && k == 1) ? 1'b1 : 1'b0)) seq_bad = 1'b1;
      if (n != 0 && k >= 2 && k <= n + 1) begin
        if (Tile_Gate !== 1'b1 || Tile_Idx !== TILE_CNT_W'(k - 2)) seq_bad = 1'b1;
      end else if (Tile_Gate !== 1'b0 || Tile_Idx !== '0) begin
        seq_bad = 1'b1;
      end
      if (Res_Valid === 1'b1) begin
        seen = 1'b1;
        v    = k;
      end
    end
    checks++;
    if (!seen || v != lat) begin
      errors++;
      $display("FAIL %s res_valid_latency: got %0d want %0d", tag, v, lat);
    end
    checks++;
    if (seq_bad) begin
      errors++;
      $display("FAIL %s sequence: tile/clear/busy pattern wrong, last Tile_Idx=%0d Tile_Gate=%b",
               tag, Tile_Idx, Tile_Gate);
    end
    exp_v = exp_q.pop_front();
    if (!seen) begin
      Start_Valid = 1'b0;
      Res_Ready   = 1'b1;
      return;
    end
    got = Res_Data;
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s res_data: got %0d want %0d", tag, $signed(got), $signed(exp_v));
    end
    if (hold > 0) begin
      hold_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge Clk);
        if (Res_Valid !== 1'b1 || Res_Data !== got || Start_Ready !== 1'b0 || Busy !== 1'b1)
          hold_bad = 1'b1;
      end
      checks++;
      if (hold_bad) begin
        errors++;
        $display("FAIL %s backpressure_hold: Res_Valid=%b Start_Ready=%b Busy=%b want 1/0/1",
                 tag, Res_Valid, Start_Ready, Busy);
      end
      Res_Ready = 1'b1;
    end
    @(negedge Clk);
    if (!keep_valid) Start_Valid = 1'b0;
    checks++;
    if (Res_Valid !== 1'b0 || Busy !== 1'b0 || Start_Ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake: Res_Valid=%b Busy=%b Start_Ready=%b want 0/0/1",
               tag, Res_Valid, Busy, Start_Ready);
    end
  endtask

  task automatic test_reset();
    GlobalReset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (Start_Ready !== 1'b0 || Busy !== 1'b0 || Tile_Idx !== '0 || Tile_Gate !== 1'b0 ||
          Neuron_Reset !== 1'b1 || Res_Data !== '0 || Res_Valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: SR=%b Busy=%b Idx=%0d Gate=%b NR=%b Data=%0d RV=%b want 0/0/0/0/1/0/0",
                 Start_Ready, Busy, Tile_Idx, Tile_Gate, Neuron_Reset, Res_Data, Res_Valid);
      end
    end
    GlobalReset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (Start_Ready !== 1'b1 || Neuron_Reset !== 1'b0 || Busy !== 1'b0 || Res_Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: SR=%b NR=%b Busy=%b RV=%b want 1/0/0/0",
               Start_Ready, Neuron_Reset, Busy, Res_Valid);
    end
  endtask

  task automatic test_varied();
    do_job(3, 1, 0, 1'b0, "varied3");
    do_job(1, 1, 0, 1'b0, "varied1");
  endtask

  task automatic test_basic();
    do_job(4, 0, 0, 1'b0, "ones4");
  endtask

  task automatic test_zero_tiles();
    do_job(0, 0, 0, 1'b0, "zero_tiles");
  endtask

  task automatic test_back_to_back();
    do_job(3, 1, 5, 1'b1, "held");
    do_job(2, 0, 0, 1'b0, "after_held");
  endtask

  task automatic test_reset_mid_job();
    bit bad;
    int t = 0;
    while (Start_Ready !== 1'b1 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    mode        = 1;
    Num_Tiles   = TILE_CNT_W'(8);
    Start_Valid = 1'b1;
    Res_Ready   = 1'b1;
    @(negedge Clk);
    Start_Valid = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (Tile_Gate !== 1'b1) begin
      errors++;
      $display("FAIL midjob_in_issue: Tile_Gate got %b want 1", Tile_Gate);
    end
    #2 GlobalReset_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Start_Ready !== 1'b0 || Tile_Gate !== 1'b0 || Tile_Idx !== '0 ||
        Neuron_Reset !== 1'b1 || Res_Valid !== 1'b0 || Res_Data !== '0) begin
      errors++;
      $display("FAIL midjob_async_reset: Busy=%b SR=%b Gate=%b Idx=%0d NR=%b RV=%b Data=%0d want 0/0/0/0/1/0/0",
               Busy, Start_Ready, Tile_Gate, Tile_Idx, Neuron_Reset, Res_Valid, Res_Data);
    end
    @(negedge Clk);
    GlobalReset_n = 1'b1;
    bad = 1'b0;
    repeat (PIPE_DEPTH + 8) begin
      @(negedge Clk);
      if (Res_Valid !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midjob_no_result: Res_Valid=%b Busy=%b want 0/0", Res_Valid, Busy);
    end
    do_job(2, 1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_relu();
    do_job(2, 2, 0, 1'b0, "neg3");
  endtask

  task automatic test_max_tiles();
    do_job(255, 1, 0, 1'b0, "max_tiles");
  endtask

  initial begin
    GlobalReset_n = 1'b0;
    Start_Valid   = 1'b0;
    Num_Tiles     = '0;
    Res_Ready     = 1'b0;
    test_reset();
    test_varied();
    test_basic();
    test_zero_tiles();
    test_back_to_back();
    test_reset_mid_job();
    test_relu();
    test_max_tiles();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
